fifo_test_a: RTL and testbench
==============================

Name: fifo_test_a

Overview:
- Self-contained FIFO exercise block.
- One start request runs a producer that pushes a counting sequence into an internal synchronous FIFO.
- A consumer drains the FIFO in parallel, accumulates a checksum and checks the sequence order.
- Busy/done handshake toward the controlling logic: start pulse in, busy level out.

Parameters:
- DATA_W, 32, width of FIFO words, producer counter and checksum.
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- COUNT, 64, number of words produced and consumed per run; range 1..2^DATA_W-1.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset_n  in  1  synchronous reset, ACTIVE-HIGH despite the name: 1 at a posedge clears all state.
- ce  in  1  clock enable; when 0, all state holds and i_run_req is ignored.
- i_run_req  in  1  start request; sampled only in IDLE with ce=1.
- o_run_busy  out  1  high while a run is in progress.
- o_sum  out  DATA_W  sum modulo 2^DATA_W of all words consumed in the last or current run.
- o_error  out  1  sticky; set if any consumed word differs from its expected value.

Behaviour:
- Reset (reset_n=1 at posedge) clears everything and overrides ce:
  - state=IDLE; o_run_busy=0; o_sum=0; o_error=0.
  - FIFO pointers=0; producer count=0; expected value=0; toggle=0.
- Reset mid-run aborts the run immediately; FIFO contents are discarded.
- States: IDLE, RUN.
- IDLE, i_run_req=1, ce=1 at edge E0:
  - go to RUN; o_run_busy=1 after E0.
  - producer count=0, expected=0, o_sum=0, o_error=0, FIFO pointers=0.
- i_run_req during RUN is ignored (no restart, no queuing).
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits wide.
  - empty when pointers are equal.
  - full when the address bits are equal and the MSBs differ.
  - Show-ahead read: head word readable combinationally; a written word becomes readable the cycle after its write edge.
- Producer, in RUN with ce=1:
  - if count<COUNT and !full: write value=count, then count++.
  - if full: stall and hold count.
  - full/empty are evaluated from pre-edge state; a write while full never occurs, even if a read happens at the same edge.
- Consumer, in RUN with ce=1, reads when !empty:
  - o_sum += head.
  - if head != expected, set o_error.
  - expected++.
- Simultaneous read and write in one cycle is allowed; occupancy is unchanged.
- Completion: the edge that performs the COUNT-th read sets state=IDLE and o_run_busy=0.
- Timing:
  - Without stall: writes at E1..E_COUNT, reads at E2..E_(COUNT+1).
  - o_run_busy is high for exactly COUNT+1 cycles.
- o_sum and o_error hold their values in IDLE until the next start or reset.
- ce=0 in any state freezes all registers, including the FIFO; busy duration stretches by the number of ce-low cycles.
- Arithmetic wraps modulo 2^DATA_W.

Optional Feature:
- Macro: FIFO_TEST_STALL_EN.
- Defined:
  - Toggle register, cleared at run start, inverts every RUN cycle with ce=1.
  - Consumer reads only when toggle=1 (pre-edge) and !empty, so reads occur at E2, E4, ..., E_(2*COUNT).
  - The FIFO reaches full and the producer stalls.
  - o_run_busy is high for exactly 2*COUNT cycles when COUNT>=1.
- Undefined: no toggle register exists; the consumer reads every non-empty cycle.

Test Plan:
- Defaults, no macro: reset 10 cycles, then one-cycle i_run_req with ce=1 -> o_run_busy=1 next cycle, high exactly 65 cycles, then 0; o_sum=2016; o_error=0.
- Defaults with FIFO_TEST_STALL_EN -> busy high exactly 128 cycles; FIFO full asserted at least once; o_sum=2016; o_error=0.
- ce low for 5 cycles mid-run -> busy lasts 70 cycles; o_sum=2016.
- i_run_req pulsed again at cycle 20 of the run -> no effect; busy total 65 cycles; o_sum=2016.
- reset_n=1 at cycle 30 of the run -> next cycle busy=0, o_sum=0, o_error=0; a new request completes normally with o_sum=2016.
- COUNT=1, DEPTH=2 -> busy high 2 cycles; o_sum=0; o_error=0. A second run back-to-back starts from IDLE and again reports o_sum=0.

Source files
------------

// File: rtl/fifo_test_a.sv
// rtl/fifo_test_a.sv - FIFO exercise block: counting producer, checking consumer, checksum.
// Optional FIFO_TEST_STALL_EN halves the consumer rate so the producer hits a full FIFO.

module fifo_test_a_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  // Extra pointer MSB separates full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset_n) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

module fifo_test_a #(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 16,
  parameter int unsigned COUNT  = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              i_run_req,
  output logic              o_run_busy,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_error
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              start;
  logic              do_write;
  logic              do_read;

  assign start    = (state == IDLE) && ce && i_run_req;
  assign do_write = (state == RUN) && ce && (count < DATA_W'(COUNT)) && !full;

`ifdef FIFO_TEST_STALL_EN
  logic toggle;
  assign do_read = (state == RUN) && ce && toggle && !empty;
`else
  assign do_read = (state == RUN) && ce && !empty;
`endif

  fifo_test_a_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start),
    .wr_en   (do_write),
    .wr_data (count),
    .rd_en   (do_read),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock) begin
    if (reset_n) begin
      state      <= IDLE;
      o_run_busy <= 1'b0;
      o_sum      <= '0;
      o_error    <= 1'b0;
      count      <= '0;
      expected   <= '0;
`ifdef FIFO_TEST_STALL_EN
      toggle     <= 1'b0;
`endif
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (i_run_req) begin
            state      <= RUN;
            o_run_busy <= 1'b1;
            o_sum      <= '0;
            o_error    <= 1'b0;
            count      <= '0;
            expected   <= '0;
`ifdef FIFO_TEST_STALL_EN
            toggle     <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef FIFO_TEST_STALL_EN
          toggle <= ~toggle;
`endif
          if (do_write) count <= count + 1'b1;
          if (do_read) begin
            o_sum    <= o_sum + head;
            expected <= expected + 1'b1;
            if (head != expected) o_error <= 1'b1;
            // The COUNT-th read ends the run on the same edge.
            if (expected == DATA_W'(COUNT - 1)) begin
              state      <= IDLE;
              o_run_busy <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_test_a.sv
// tb/tb_fifo_test_a.sv - bench for fifo_test_a: default and COUNT=1/DEPTH=2 instances vs run-length model.

module tb_fifo_test_a;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b0;
  logic          i_run_req = 1'b0;
  logic          busy_a, busy_b, err_a, err_b;
  logic [DW-1:0] sum_a, sum_b;

  always #5 clock = ~clock;

  fifo_test_a dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .i_run_req(i_run_req),
    .o_run_busy(busy_a), .o_sum(sum_a), .o_error(err_a)
  );

  fifo_test_a #(.DATA_W(DW), .DEPTH(2), .COUNT(1)) dut_small (
    .clock(clock), .reset_n(reset_n), .ce(ce), .i_run_req(i_run_req),
    .o_run_busy(busy_b), .o_sum(sum_b), .o_error(err_b)
  );

  int     checks = 0;
  int     passed = 0;
  // Model: a run needs a fixed number of enabled edges, then reports the sum 0+1+..+(COUNT-1).
  int     cnt [2] = '{64, 1};
  int     base [2];
  longint sum_done [2];
  bit     m_busy [2];
  int     m_left [2];
  longint m_sum [2];
  bit     saw_full = 1'b0;

`ifdef FIFO_TEST_STALL_EN
  always @(posedge clock) if (dut.u_fifo.full === 1'b1) saw_full <= 1'b1;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input bit r, input bit c, input bit q);
    reset_n = r; ce = c; i_run_req = q;
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_busy[i] = 1'b0;
        m_sum[i]  = 0;
      end else if (c) begin
        if (!m_busy[i]) begin
          if (q) begin
            m_busy[i] = 1'b1;
            m_left[i] = base[i];
            m_sum[i]  = 0;
          end
        end else begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_busy[i] = 1'b0;
            m_sum[i]  = sum_done[i];
          end
        end
      end
    end
    chk("busy_a", busy_a, m_busy[0]);
    chk("busy_b", busy_b, m_busy[1]);
    if (!m_busy[0]) begin
      chk("sum_a", sum_a, m_sum[0]);
      chk("err_a", err_a, 0);
    end
    if (!m_busy[1]) begin
      chk("sum_b", sum_b, m_sum[1]);
      chk("err_b", err_b, 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
`ifdef FIFO_TEST_STALL_EN
      base[i] = 2 * cnt[i];
`else
      base[i] = cnt[i] + 1;
`endif
      sum_done[i] = (longint'(cnt[i]) * (cnt[i] - 1) / 2) & 64'hFFFF_FFFF;
      m_busy[i] = 1'b0;
      m_left[i] = 0;
      m_sum[i]  = 0;
    end

    // Reset with ce both low and high; reset must win.
    repeat (5) tick(1'b1, 1'b0, 1'b1);
    repeat (5) tick(1'b1, 1'b1, 1'b1);

    // Plain run.
    tick(1'b0, 1'b1, 1'b1);
    idle(140);

    // ce low for 5 cycles mid-run.
    tick(1'b0, 1'b1, 1'b1);
    idle(19);
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    idle(140);

    // Second request mid-run is ignored by the long run.
    tick(1'b0, 1'b1, 1'b1);
    idle(19);
    tick(1'b0, 1'b1, 1'b1);
    idle(140);

    // Reset mid-run aborts, then a fresh run completes.
    tick(1'b0, 1'b1, 1'b1);
    idle(29);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    idle(140);

    // Random ce gaps, stray requests and occasional resets.
    repeat (25) begin
      tick(1'b0, 1'b1, 1'b1);
      repeat (180)
        tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    idle(300);

`ifdef FIFO_TEST_STALL_EN
    chk("fifo_full_seen", saw_full, 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
